data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/data_mem_arbiter_if.sv | 51 +++++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/data_mem_arbiter.sv | 106 ++++++++++
 tb/tb_data_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NPORTS     = 2;
  localparam int unsigned ADDR_W     = 32;
  // Widest data path the latched request can carry; DW must not exceed it.
  localparam int unsigned DATA_W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic                  byte_mode;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W_MAX-1:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester ports and RAM port of the data memory arbiter, bundled as one interface.
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned G  = 10,
  parameter int unsigned DW = 32
);

  logic          req0_i;
  logic          we0_i;
  logic [31:0]   addr0_i;
  logic [DW-1:0] wdata0_i;
  logic          byte0_i;
  logic          gnt0_o;
  logic          rvalid0_o;
  logic [DW-1:0] rdata0_o;

  logic          req1_i;
  logic          we1_i;
  logic [31:0]   addr1_i;
  logic [DW-1:0] wdata1_i;
  logic          byte1_i;
  logic          gnt1_o;
  logic          rvalid1_o;
  logic [DW-1:0] rdata1_o;

  logic [G-1:0]  mem_address_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_we_o;
  logic          mem_byte_o;
  logic [DW-1:0] mem_data_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i, byte0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i, byte1_i,
    input  mem_data_i,
    output gnt0_o, rvalid0_o, rdata0_o,
    output gnt1_o, rvalid1_o, rdata1_o,
    output mem_address_o, mem_data_o, mem_we_o, mem_byte_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i, byte0_i,
    output req1_i, we1_i, addr1_i, wdata1_i, byte1_i,
    output mem_data_i,
    input  gnt0_o, rvalid0_o, rdata0_o,
    input  gnt1_o, rvalid1_o, rdata1_o,
    input  mem_address_o, mem_data_o, mem_we_o, mem_byte_o
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port ptr_i favours.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  logic              ptr_i,
  output logic [NPORTS-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM with registered read data.
// One access every two cycles at best: sample -> ACCESS (gnt, RAM op) -> RESP (rvalid).
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned G  = 10,
  parameter int unsigned DW = 32
) (
  input  logic               CLK,
  input  logic               RST,
  data_mem_arbiter_if.slave  bus
);

  state_e                   state_q;
  logic                     ptr_q;
  req_t                     cur_q;
  logic [NPORTS-1:0]        win_q;
  logic [NPORTS-1:0]        gnt_q;
  logic [NPORTS-1:0]        rvalid_q;
  logic                     mem_we_q;
  logic [NPORTS-1:0][DW-1:0] rdata_q;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] win;
  req_t              cand;

  assign req = {bus.req1_i, bus.req0_i};

  rr_arbiter2 u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  // Winner's qualifiers; address truncated to the RAM width on capture.
  always_comb begin
    cand = '0;
    if (win[1]) begin
      cand.we             = bus.we1_i;
      cand.byte_mode      = bus.byte1_i;
      cand.addr[G-1:0]    = bus.addr1_i[G-1:0];
      cand.wdata[DW-1:0]  = bus.wdata1_i;
    end else begin
      cand.we             = bus.we0_i;
      cand.byte_mode      = bus.byte0_i;
      cand.addr[G-1:0]    = bus.addr0_i[G-1:0];
      cand.wdata[DW-1:0]  = bus.wdata0_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cur_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_we_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_we_q <= 1'b0;
      for (int unsigned n = 0; n < NPORTS; n++) begin
        if (rvalid_q[n]) rdata_q[n] <= bus.mem_data_i;
      end
      unique case (state_q)
        IDLE, RESP: begin
          if (|req) begin
            cur_q    <= cand;
            win_q    <= win;
            gnt_q    <= win;
            mem_we_q <= cand.we;
            // Favour the other port on the next tie.
            ptr_q    <= win[0];
            state_q  <= ACCESS;
          end else begin
            state_q  <= IDLE;
          end
        end
        ACCESS: begin
          rvalid_q <= cur_q.we ? '0 : win_q;
          state_q  <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0_o        = gnt_q[0];
  assign bus.gnt1_o        = gnt_q[1];
  assign bus.rvalid0_o     = rvalid_q[0];
  assign bus.rvalid1_o     = rvalid_q[1];
  // RAM read data is only present during RESP, so pass it through and hold it afterwards.
  assign bus.rdata0_o      = rvalid_q[0] ? bus.mem_data_i : rdata_q[0];
  assign bus.rdata1_o      = rvalid_q[1] ? bus.mem_data_i : rdata_q[1];
  assign bus.mem_address_o = cur_q.addr[G-1:0];
  assign bus.mem_data_o    = cur_q.wdata[DW-1:0];
  assign bus.mem_byte_o    = cur_q.byte_mode;
  assign bus.mem_we_o      = mem_we_q;

  logic unused_bits;
  assign unused_bits = ^{bus.addr0_i, bus.addr1_i, cur_q};

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and random-traffic bench for data_mem_arbiter with a transaction-level model.
module tb_data_mem_arbiter;

  localparam int unsigned G  = 10;
  localparam int unsigned DW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  data_mem_arbiter_if #(.G(G), .DW(DW)) bus ();

  data_mem_arbiter #(.G(G), .DW(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int issued  = 0;
  int gnt_total = 0;
  int we_cycles = 0;

  int           gnt_log[$];
  int           gnt_cyc[$];
  logic [G-1:0] gnt_addr[$];
  int           rv_port[$];
  int           rv_cyc[$];
  logic [DW-1:0] rv_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete(); gnt_addr.delete();
    rv_port.delete(); rv_cyc.delete(); rv_data.delete();
    we_cycles = 0;
  endtask

  // RAM: registered read data, write on mem_we_o, read-before-write.
  initial begin : ram
    logic [DW-1:0] ram [0:(1<<G)-1];
    for (int i = 0; i < (1 << G); i++) ram[i] = '0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge CLK);
      bus.mem_data_i <= ram[bus.mem_address_o];
      if (bus.mem_we_o) ram[bus.mem_address_o] <= bus.mem_data_o;
    end
  end

  // Transaction model: one access takes the cycle after sampling (grant) and the next (response).
  initial begin : model_chk
    logic [DW-1:0] mmem [0:(1<<G)-1];
    logic          m_acc, m_we, m_byte, m_last, m_win;
    logic          s_rst, s_r0, s_r1;
    logic [G-1:0]  m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    e_gnt, e_rv;
    logic          e_mwe;
    logic [DW-1:0] e_rd [2];
    for (int i = 0; i < (1 << G); i++) mmem[i] = '0;
    m_acc = 0; m_we = 0; m_byte = 0; m_last = 1; m_win = 0;
    m_addr = '0; m_wdata = '0; e_rd[0] = '0; e_rd[1] = '0;
    forever begin
      @(posedge CLK);
      cyc++;
      s_rst = RST; s_r0 = bus.req0_i; s_r1 = bus.req1_i;
      e_gnt = '0; e_rv = '0; e_mwe = 1'b0;
      if (m_acc && m_we) mmem[m_addr] = m_wdata;
      if (s_rst) begin
        m_acc = 0; m_we = 0; m_byte = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; e_rd[0] = '0; e_rd[1] = '0;
      end else if (m_acc) begin
        m_acc = 0;
        if (!m_we) begin
          e_rv[m_win] = 1'b1;
          e_rd[m_win] = mmem[m_addr];
        end
      end else if (s_r0 || s_r1) begin
        m_win  = (s_r0 && s_r1) ? ~m_last : s_r1;
        m_last = m_win;
        if (m_win) begin
          m_we = bus.we1_i; m_byte = bus.byte1_i;
          m_addr = bus.addr1_i[G-1:0]; m_wdata = bus.wdata1_i;
        end else begin
          m_we = bus.we0_i; m_byte = bus.byte0_i;
          m_addr = bus.addr0_i[G-1:0]; m_wdata = bus.wdata0_i;
        end
        m_acc = 1; e_gnt[m_win] = 1'b1; e_mwe = m_we;
      end
      @(negedge CLK);
      chk("gnt0", bus.gnt0_o, e_gnt[0]);
      chk("gnt1", bus.gnt1_o, e_gnt[1]);
      chk("rvalid0", bus.rvalid0_o, e_rv[0]);
      chk("rvalid1", bus.rvalid1_o, e_rv[1]);
      chk("rdata0", bus.rdata0_o, e_rd[0]);
      chk("rdata1", bus.rdata1_o, e_rd[1]);
      chk("mem_we", bus.mem_we_o, e_mwe);
      chk("mem_address", bus.mem_address_o, m_addr);
      chk("mem_data", bus.mem_data_o, m_wdata);
      chk("mem_byte", bus.mem_byte_o, m_byte);
      chk("gnt_onehot", bus.gnt0_o & bus.gnt1_o, 0);
      chk("rvalid_onehot", bus.rvalid0_o & bus.rvalid1_o, 0);
      if (bus.gnt0_o || bus.gnt1_o) begin
        gnt_total++;
        gnt_log.push_back(bus.gnt1_o ? 1 : 0);
        gnt_cyc.push_back(cyc);
        gnt_addr.push_back(bus.mem_address_o);
      end
      if (bus.mem_we_o) we_cycles++;
      if (bus.rvalid0_o || bus.rvalid1_o) begin
        rv_port.push_back(bus.rvalid1_o ? 1 : 0);
        rv_cyc.push_back(cyc);
        rv_data.push_back(bus.rvalid1_o ? bus.rdata1_o : bus.rdata0_o);
      end
    end
  end

  // Call at posedge+2; returns at posedge+2 after the edge that ends the grant cycle.
  task automatic do_req(input int p, input logic we, input logic [31:0] a,
                        input logic [DW-1:0] d, input logic b);
    logic got = 1'b0;
    if (p == 0) begin
      bus.req0_i = 1; bus.we0_i = we; bus.addr0_i = a; bus.wdata0_i = d; bus.byte0_i = b;
    end else begin
      bus.req1_i = 1; bus.we1_i = we; bus.addr1_i = a; bus.wdata1_i = d; bus.byte1_i = b;
    end
    issued++;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      got = (p == 0) ? bus.gnt0_o : bus.gnt1_o;
    end
    chk($sformatf("grant_seen_p%0d", p), got, 1);
    @(posedge CLK); #2;
    if (p == 0) bus.req0_i = 0; else bus.req1_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rd_cyc;
    int rnd_end;
    bus.req0_i = 0; bus.we0_i = 0; bus.addr0_i = '0; bus.wdata0_i = '0; bus.byte0_i = 0;
    bus.req1_i = 0; bus.we1_i = 0; bus.addr1_i = '0; bus.wdata1_i = '0; bus.byte1_i = 0;

    @(negedge CLK);
    chk("reset_mem_we", bus.mem_we_o, 0);
    chk("reset_mem_address", bus.mem_address_o, 0);
    chk("reset_rdata0", bus.rdata0_o, 0);
    @(posedge CLK); #2;
    RST = 0;

    // Both ports read continuously straight out of reset.
    clear_logs();
    fork
      for (int i = 0; i < 4; i++) do_req(0, 1'b0, 32'(i), '0, 1'b0);
      for (int i = 0; i < 4; i++) do_req(1, 1'b0, 32'(i + 8), '0, 1'b1);
    join
    idle(3);
    chk("alt_count", gnt_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("alt_gnt%0d", i), gnt_log[i], i % 2);
    for (int i = 0; i < 7; i++) chk($sformatf("alt_spacing%0d", i), gnt_cyc[i+1] - gnt_cyc[i], 2);
    for (int i = 0; i < 8; i++) chk($sformatf("alt_rvport%0d", i), rv_port[i], i % 2);

    // Port 0 write then read back.
    clear_logs();
    do_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    rd_cyc = cyc;
    do_req(0, 1'b0, 32'd5, '0, 1'b0);
    idle(2);
    chk("wr_rd_gnts", gnt_log.size(), 2);
    chk("wr_we_cycles", we_cycles, 1);
    chk("rd_rvport", rv_port[0], 0);
    chk("rd_data", rv_data[0], 32'hDEAD_BEEF);
    chk("rd_latency", rv_cyc[0] - rd_cyc, 2);

    // Address truncation: write via 0x004, read via 0x404 on port 1.
    clear_logs();
    do_req(0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b1);
    do_req(1, 1'b0, 32'h0000_0404, '0, 1'b0);
    idle(2);
    chk("trunc_addr", gnt_addr[1], 10'h004);
    chk("trunc_data", bus.rdata1_o, 32'h1234_5678);
    chk("loser_rdata_hold", bus.rdata0_o, 32'hDEAD_BEEF);

    // Reset during the ACCESS cycle of a port-1 write.
    bus.req1_i = 1; bus.we1_i = 1; bus.addr1_i = 32'h3F0; bus.wdata1_i = 32'hCAFE; bus.byte1_i = 0;
    issued++;
    @(posedge CLK); #2;
    RST = 1; bus.req1_i = 0;
    @(posedge CLK); #2;
    RST = 0;
    clear_logs();
    @(negedge CLK);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_rdata1", bus.rdata1_o, 0);
    idle(3);
    chk("rst_no_gnt", gnt_log.size(), 0);
    chk("rst_no_rvalid", rv_port.size(), 0);
    fork
      do_req(0, 1'b0, 32'd5, '0, 1'b0);
      do_req(1, 1'b0, 32'd4, '0, 1'b0);
    join
    idle(2);
    chk("rst_first_winner", gnt_log[0], 0);
    chk("rst_second_winner", gnt_log[1], 1);

    // Random traffic on both ports.
    rnd_end = cyc + 2000;
    fork
      while (cyc < rnd_end) begin
        logic [31:0] a;
        idle($urandom_range(0, 3));
        a = $urandom; a[9:4] = '0;
        do_req(0, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      end
      while (cyc < rnd_end) begin
        logic [31:0] a;
        idle($urandom_range(0, 3));
        a = $urandom; a[9:4] = '0;
        do_req(1, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      end
    join
    idle(3);
    chk("grant_count", gnt_total, issued);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
